// File: rtl/intp_pkg.sv
// Shared constants for the interrupt conditioning and control blocks.
package intp_pkg;

  localparam int DEF_NUM_OF_PERIPHERALS = 16;
  localparam int DEF_ADDR_WIDTH         = 2;

  // Index width for a source vector of n entries; never narrower than 1 bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_ID_WIDTH = id_width(DEF_NUM_OF_PERIPHERALS);

  // Register word addresses
  localparam logic [1:0] REG_MASK    = 2'd0;
  localparam logic [1:0] REG_MODE    = 2'd1;
  localparam logic [1:0] REG_PENDING = 2'd2;
  localparam logic [1:0] REG_RAW     = 2'd3;

  // Per-source mode bit encodings
  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

endpackage

// File: rtl/intp_sync_edge.sv
// Two-flop synchroniser for one raw interrupt line plus a previous-sample
// flop for rising-edge detection.
module intp_sync_edge (
  input  logic gclk,
  input  logic grst_n,
  input  logic raw_i,
  output logic s_o,
  output logic rise_o
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  // Next-state: shift the raw line through the synchroniser and history flop.
  always_comb begin
    sync1_d = raw_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // State flops; everything clears on reset so no stale history survives.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign s_o    = sync2_q;
  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/intp_source_cond.sv
// Interrupt source conditioning: synchronise raw lines, apply per-source
// level/edge mode, latch pending events, mask them toward intp_ctrl, and
// expose mask/mode/pending/raw through a small APB register file.
module intp_source_cond
  import intp_pkg::*;
#(
  parameter int NUM_OF_PERIPHERALS = DEF_NUM_OF_PERIPHERALS,
  parameter int ADDR_WIDTH         = DEF_ADDR_WIDTH,
  parameter int ID_WIDTH           = DEF_ID_WIDTH
) (
  input  logic                          pclk_i,
  input  logic                          prst_i,
  input  logic [ADDR_WIDTH-1:0]         paddr_i,
  input  logic                          pwrite_i,
  input  logic                          penable_i,
  input  logic [NUM_OF_PERIPHERALS-1:0] pwdata_i,
  output logic [NUM_OF_PERIPHERALS-1:0] prdata_o,
  output logic                          pready_o,
  output logic                          perror_o,
  input  logic [NUM_OF_PERIPHERALS-1:0] irq_raw_i,
  input  logic                          intp_serviced_i,
  input  logic [ID_WIDTH-1:0]           intp_to_service_i,
  output logic [NUM_OF_PERIPHERALS-1:0] intp_active_o
);

  logic [NUM_OF_PERIPHERALS-1:0] s, rise;
  logic [NUM_OF_PERIPHERALS-1:0] mask_q, mask_d;
  logic [NUM_OF_PERIPHERALS-1:0] mode_q, mode_d;
  logic [NUM_OF_PERIPHERALS-1:0] pend_q, pend_d;
  logic [NUM_OF_PERIPHERALS-1:0] prdata_q, prdata_d;
  logic                          pready_q, pready_d;
  logic                          perror_q, perror_d;
  logic [NUM_OF_PERIPHERALS-1:0] w1c;
  logic                          acc;

  // A line already high at reset release does produce a rise once the
  // synchroniser fills, but mode resets to level, so it cannot reach pending
  // as an edge event before software has had time to program MODE.
  for (genvar gi = 0; gi < NUM_OF_PERIPHERALS; gi++) begin : g_src
    intp_sync_edge u_sync (
      .gclk   (pclk_i),
      .grst_n (prst_i),
      .raw_i  (irq_raw_i[gi]),
      .s_o    (s[gi]),
      .rise_o (rise[gi])
    );
  end

  // APB decode: accept when enabled and not already completing; pready
  // self-clears on the following edge so a held enable gives 1 access / 2 cycles.
  always_comb begin
    acc      = penable_i & ~pready_q;
    mask_d   = mask_q;
    mode_d   = mode_q;
    prdata_d = prdata_q;
    pready_d = acc;
    perror_d = 1'b0;
    w1c      = '0;
    if (acc && pwrite_i) begin
      case (paddr_i)
        ADDR_WIDTH'(REG_MASK):    mask_d   = pwdata_i;
        ADDR_WIDTH'(REG_MODE):    mode_d   = pwdata_i;
        ADDR_WIDTH'(REG_PENDING): w1c      = pwdata_i;
        ADDR_WIDTH'(REG_RAW):     perror_d = 1'b1;
        default: ;
      endcase
    end else if (acc) begin
      case (paddr_i)
        ADDR_WIDTH'(REG_MASK):    prdata_d = mask_q;
        ADDR_WIDTH'(REG_MODE):    prdata_d = mode_q;
        ADDR_WIDTH'(REG_PENDING): prdata_d = pend_q;
        ADDR_WIDTH'(REG_RAW):     prdata_d = s;
        default:                  prdata_d = '0;
      endcase
    end
  end

  // Pending update: level sources mirror s; edge sources latch rises, and a
  // rise in the same cycle as a clear wins so no event is dropped.
  always_comb begin
    pend_d = pend_q;
    for (int i = 0; i < NUM_OF_PERIPHERALS; i++) begin
      if (mode_q[i] == MODE_LEVEL) begin
        pend_d[i] = s[i];
      end else begin
        pend_d[i] = rise[i] |
                    (pend_q[i] & ~(w1c[i] |
                     (intp_serviced_i && (intp_to_service_i == ID_WIDTH'(i)))));
      end
    end
  end

  // Register state; reset leaves every source masked, level, and idle.
  always_ff @(posedge pclk_i or negedge prst_i) begin
    if (!prst_i) begin
      mask_q   <= '0;
      mode_q   <= '0;
      pend_q   <= '0;
      prdata_q <= '0;
      pready_q <= 1'b0;
      perror_q <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      prdata_q <= prdata_d;
      pready_q <= pready_d;
      perror_q <= perror_d;
    end
  end

  assign prdata_o      = prdata_q;
  assign pready_o      = pready_q;
  assign perror_o      = perror_q;
  assign intp_active_o = pend_q & mask_q;

endmodule
